// File: rtl/mips_mc_control_fsm_if.sv
// Memory-side handshake bundle between the multi-cycle control FSM and the
// unified instruction/data memory.
//
//   MEM_READY  memory completes the current access this cycle
//   MEM_RD     read strobe (instruction fetch or load)
//   MEM_WR     write strobe (store), held until MEM_READY
//   IorD       address select: 0 = PC, 1 = ALU_REG_OUT
//
// Handshake: an access is requested while MEM_RD or MEM_WR is high. It
// completes on the rising clock edge where MEM_READY is also high. The
// requester holds its strobe and address select steady until that edge.
interface mips_mc_control_fsm_if;
    logic MEM_READY;
    logic MEM_RD;
    logic MEM_WR;
    logic IorD;

    modport master (input MEM_READY, output MEM_RD, output MEM_WR, output IorD);
    modport slave  (output MEM_READY, input MEM_RD, input MEM_WR, input IorD);
endinterface

// File: rtl/mips_mc_control_fsm.sv
// Multi-cycle main control unit for the 32-bit MIPS core.
// Sequences fetch / decode / execute / memory / write-back and raises
// precise exceptions for undefined instructions and signed overflow.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   Instr             instruction register contents
//   ZF_OUT, OF_OUT    ALU zero / signed-overflow flags (combinational)
//   mem               memory handshake (MEM_READY in; MEM_RD, MEM_WR, IorD out)
//   IR_WE, PC_WE      instruction register / PC load enables
//   PC_SRC            next-PC select
//   EPC_EN            EPC capture enable
//   REG_DATA_SEL      load extension select
//   MEMtoREG          register write-data select
//   ALU_SEL1/2        ALU operand selects
//   Reg_Dest          destination register select
//   REG_WS            register file write
//   CAUSE_EN/SEL      Cause register load and cause code
//   SIGNEXT_SEL       immediate extension (0 sign, 1 zero)
//   ALU_CONTROL       ALU operation
//   STATE             current state encoding (debug)
module mips_mc_control_fsm #(
    parameter int INSTR_WIDTH    = 32,
    parameter int EXC_STATE_WAIT = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [INSTR_WIDTH-1:0] Instr,
    input  logic                   ZF_OUT,
    input  logic                   OF_OUT,
    mips_mc_control_fsm_if.master  mem,
    output logic                   IR_WE,
    output logic                   PC_WE,
    output logic [2:0]             PC_SRC,
    output logic                   EPC_EN,
    output logic [2:0]             REG_DATA_SEL,
    output logic [2:0]             MEMtoREG,
    output logic [2:0]             ALU_SEL2,
    output logic                   ALU_SEL1,
    output logic [1:0]             Reg_Dest,
    output logic                   REG_WS,
    output logic                   CAUSE_EN,
    output logic                   CAUSE_SEL,
    output logic                   SIGNEXT_SEL,
    output logic [3:0]             ALU_CONTROL,
    output logic [4:0]             STATE
);

    typedef enum logic [4:0] {
        RST_ST    = 5'd0,
        FETCH     = 5'd1,
        DECODE    = 5'd2,
        EXEC_R    = 5'd3,
        EXEC_I    = 5'd4,
        WB_R      = 5'd5,
        WB_I      = 5'd6,
        MEM_ADDR  = 5'd7,
        MEM_READ  = 5'd8,
        MEM_WRITE = 5'd9,
        MEM_WB    = 5'd10,
        BRANCH    = 5'd11,
        JUMP      = 5'd12,
        JAL       = 5'd13,
        JR        = 5'd14,
        MFC0      = 5'd15,
        EXC_OVF   = 5'd16,
        EXC_UND   = 5'd17,
        EXC_WAIT  = 5'd18
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_COP0 = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2A;

    // Last value of the wait counter before returning to FETCH; only
    // meaningful when EXC_STATE_WAIT is non-zero.
    localparam logic [3:0] WAIT_LAST = 4'(EXC_STATE_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;

    logic [5:0] op, funct;
    logic [4:0] rs, rd;
    logic       r_alu_op, is_load;
    logic [3:0] r_alu_ctrl;
    logic       unused_instr_bits;

    assign op    = Instr[31:26];
    assign rs    = Instr[25:21];
    assign rd    = Instr[15:11];
    assign funct = Instr[5:0];
    assign unused_instr_bits = ^{Instr[20:16], Instr[10:6]};

    always_comb begin
        r_alu_op   = 1'b1;
        r_alu_ctrl = ALU_ADD;
        case (funct)
            FN_ADD:  r_alu_ctrl = ALU_ADD;
            FN_SUB:  r_alu_ctrl = ALU_SUB;
            FN_AND:  r_alu_ctrl = ALU_AND;
            FN_OR:   r_alu_ctrl = ALU_OR;
            FN_SLT:  r_alu_ctrl = ALU_SLT;
            FN_SLL:  r_alu_ctrl = ALU_SLL;
            FN_SRL:  r_alu_ctrl = ALU_SRL;
            default: r_alu_op   = 1'b0;
        endcase
    end

    assign is_load = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                     (op == OP_LB) || (op == OP_LBU);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= RST_ST;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == EXC_WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem.MEM_RD   = 1'b0;
        mem.MEM_WR   = 1'b0;
        mem.IorD     = 1'b0;
        IR_WE        = 1'b0;
        PC_WE        = 1'b0;
        PC_SRC       = 3'd0;
        EPC_EN       = 1'b0;
        REG_DATA_SEL = 3'd0;
        MEMtoREG     = 3'd0;
        ALU_SEL2     = 3'd0;
        ALU_SEL1     = 1'b0;
        Reg_Dest     = 2'd0;
        REG_WS       = 1'b0;
        CAUSE_EN     = 1'b0;
        CAUSE_SEL    = 1'b0;
        SIGNEXT_SEL  = 1'b0;
        ALU_CONTROL  = ALU_AND;

        case (state)
            RST_ST: state_nxt = FETCH;

            FETCH: begin
                // PC+4 is computed and loaded in the same cycle the fetch completes.
                mem.MEM_RD  = 1'b1;
                ALU_SEL2    = 3'd1;
                ALU_CONTROL = ALU_ADD;
                IR_WE       = mem.MEM_READY;
                PC_WE       = mem.MEM_READY;
                if (mem.MEM_READY) state_nxt = DECODE;
            end

            DECODE: begin
                // Branch target (PC+4 + imm<<2) is speculatively parked in ALU_REG.
                ALU_SEL2    = 3'd3;
                ALU_CONTROL = ALU_ADD;
                if (is_load || op == OP_SW)                 state_nxt = MEM_ADDR;
                else if (op == OP_RTYPE && r_alu_op)        state_nxt = EXEC_R;
                else if (op == OP_RTYPE && funct == FN_JR)  state_nxt = JR;
                else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)
                                                            state_nxt = EXEC_I;
                else if (op == OP_BEQ || op == OP_BNE)      state_nxt = BRANCH;
                else if (op == OP_J)                        state_nxt = JUMP;
                else if (op == OP_JAL)                      state_nxt = JAL;
                else if (op == OP_COP0 && rs == 5'd0)       state_nxt = MFC0;
                else                                        state_nxt = EXC_UND;
            end

            EXEC_R: begin
                ALU_SEL1    = 1'b1;
                ALU_CONTROL = r_alu_ctrl;
                if (OF_OUT && (funct == FN_ADD || funct == FN_SUB)) state_nxt = EXC_OVF;
                else                                                state_nxt = WB_R;
            end

            EXEC_I: begin
                ALU_SEL1 = 1'b1;
                ALU_SEL2 = 3'd2;
                if (op == OP_ADDI) begin
                    ALU_CONTROL = ALU_ADD;
                end else begin
                    SIGNEXT_SEL = 1'b1;
                    ALU_CONTROL = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                end
                if (op == OP_ADDI && OF_OUT) state_nxt = EXC_OVF;
                else                         state_nxt = WB_I;
            end

            WB_R: begin
                REG_WS    = 1'b1;
                Reg_Dest  = 2'd1;
                state_nxt = FETCH;
            end

            WB_I: begin
                REG_WS    = 1'b1;
                state_nxt = FETCH;
            end

            MEM_ADDR: begin
                ALU_SEL1    = 1'b1;
                ALU_SEL2    = 3'd2;
                ALU_CONTROL = ALU_ADD;
                state_nxt   = (op == OP_SW) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                mem.MEM_RD = 1'b1;
                mem.IorD   = 1'b1;
                if (mem.MEM_READY) state_nxt = MEM_WB;
            end

            MEM_WRITE: begin
                mem.MEM_WR = 1'b1;
                mem.IorD   = 1'b1;
                if (mem.MEM_READY) state_nxt = FETCH;
            end

            MEM_WB: begin
                REG_WS   = 1'b1;
                MEMtoREG = 3'd4;
                case (op)
                    OP_LBU:  REG_DATA_SEL = 3'd1;
                    OP_LB:   REG_DATA_SEL = 3'd2;
                    OP_LHU:  REG_DATA_SEL = 3'd3;
                    OP_LH:   REG_DATA_SEL = 3'd4;
                    default: REG_DATA_SEL = 3'd0;
                endcase
                state_nxt = FETCH;
            end

            BRANCH: begin
                ALU_SEL1    = 1'b1;
                ALU_CONTROL = ALU_SUB;
                PC_SRC      = 3'd1;
                PC_WE       = (op == OP_BNE) ? ~ZF_OUT : ZF_OUT;
                state_nxt   = FETCH;
            end

            JUMP: begin
                PC_SRC    = 3'd2;
                PC_WE     = 1'b1;
                state_nxt = FETCH;
            end

            JAL: begin
                // PC already holds PC+4 here, so it is the return address.
                PC_SRC    = 3'd2;
                PC_WE     = 1'b1;
                REG_WS    = 1'b1;
                Reg_Dest  = 2'd2;
                MEMtoREG  = 3'd5;
                state_nxt = FETCH;
            end

            JR: begin
                PC_SRC    = 3'd3;
                PC_WE     = 1'b1;
                state_nxt = FETCH;
            end

            MFC0: begin
                // Only EPC (14) and Cause (13) exist; other CP0 registers trap
                // without touching the register file.
                if (rd == 5'd14) begin
                    REG_WS    = 1'b1;
                    MEMtoREG  = 3'd2;
                    state_nxt = FETCH;
                end else if (rd == 5'd13) begin
                    REG_WS    = 1'b1;
                    MEMtoREG  = 3'd3;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = EXC_UND;
                end
            end

            EXC_OVF, EXC_UND: begin
                EPC_EN    = 1'b1;
                CAUSE_EN  = 1'b1;
                CAUSE_SEL = (state == EXC_OVF);
                PC_SRC    = 3'd4;
                PC_WE     = 1'b1;
                state_nxt = (EXC_STATE_WAIT == 0) ? FETCH : EXC_WAIT;
            end

            EXC_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nxt = FETCH;
            end

            default: state_nxt = RST_ST;
        endcase
    end

    assign STATE = state;

endmodule
